// File: rtl/ewb_drain.sv
// rtl/ewb_drain.sv - eviction write buffer drain engine
// Pops dirty lines from the write buffer and bursts them to memory as BEAT-wide writes.
module ewb_drain #(
    parameter int WIDTH = 256,
    parameter int BEAT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty_i,
    input  logic             full_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [31:0]      addr_i,
    output logic             yumi_o,
    input  logic             rd_pending_i,
    output logic [31:0]      bmem_address_o,
    output logic             bmem_write_o,
    output logic [BEAT-1:0]  bmem_wdata_o,
    input  logic             bmem_resp_i,
    output logic             busy_o,
    output logic [15:0]      drained_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [26:0]      tag_q, tag_d;
    logic [15:0]      drained_q, drained_d;
    logic             in_write;

    // Byte offset within the line is irrelevant: bursts always start at the line base.
    logic unused_offset;
    assign unused_offset = ^addr_i[4:0];

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        data_d    = data_q;
        tag_d     = tag_q;
        drained_d = drained_q;
        case (state_q)
            ST_IDLE: begin
                // Pending read misses win unless the buffer is full.
                if (!empty_i && (!rd_pending_i || full_i)) begin
                    state_d = ST_WRITE;
                    data_d  = data_i;
                    tag_d   = addr_i[31:5];
                    beat_d  = 2'd0;
                end
            end
            ST_WRITE: begin
                if (bmem_resp_i) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (drained_q != 16'hFFFF) begin
                    drained_d = drained_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= 2'd0;
            data_q    <= '0;
            tag_q     <= '0;
            drained_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            drained_q <= drained_d;
        end
    end

    assign in_write       = (state_q == ST_WRITE);
    assign bmem_write_o   = in_write;
    assign bmem_address_o = in_write ? {tag_q, 5'b0} : 32'd0;
    assign bmem_wdata_o   = in_write ? data_q[BEAT*int'(beat_q) +: BEAT] : '0;
    assign yumi_o         = (state_q == ST_ACK);
    assign busy_o         = (state_q != ST_IDLE);
    assign drained_o      = drained_q;

endmodule

// File: tb/tb_ewb_drain.sv
// tb/tb_ewb_drain.sv - directed self-checking bench for ewb_drain
module tb_ewb_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         empty_i;
    logic         full_i;
    logic [255:0] data_i;
    logic [31:0]  addr_i;
    logic         yumi_o;
    logic         rd_pending_i;
    logic [31:0]  bmem_address_o;
    logic         bmem_write_o;
    logic [63:0]  bmem_wdata_o;
    logic         bmem_resp_i;
    logic         busy_o;
    logic [15:0]  drained_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] l1 [4];
    logic [63:0] l2 [4];
    logic [63:0] l3 [4];
    logic [63:0] l4 [4];
    int          yumi_cyc [3];
    int          pops;

    always #5 clk = ~clk;

    ewb_drain #(.WIDTH(256), .BEAT(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .empty_i        (empty_i),
        .full_i         (full_i),
        .data_i         (data_i),
        .addr_i         (addr_i),
        .yumi_o         (yumi_o),
        .rd_pending_i   (rd_pending_i),
        .bmem_address_o (bmem_address_o),
        .bmem_write_o   (bmem_write_o),
        .bmem_wdata_o   (bmem_wdata_o),
        .bmem_resp_i    (bmem_resp_i),
        .busy_o         (busy_o),
        .drained_o      (drained_o)
    );

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        expect_eq({tag, "_wr"},   {63'd0, bmem_write_o}, 64'd0);
        expect_eq({tag, "_addr"}, {32'd0, bmem_address_o}, 64'd0);
        expect_eq({tag, "_wd"},   bmem_wdata_o, 64'd0);
        expect_eq({tag, "_yumi"}, {63'd0, yumi_o}, 64'd0);
        expect_eq({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    endtask

    // Zero-wait burst; caller has already set up the head entry before the launching edge.
    task automatic run_burst(input string tag, input logic [31:0] exp_addr,
                             input logic [63:0] eb [4], input bit disturb);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expect_eq({tag, "_wr"},   {63'd0, bmem_write_o}, 64'd1);
            expect_eq({tag, "_addr"}, {32'd0, bmem_address_o}, {32'd0, exp_addr});
            expect_eq({tag, "_wd"},   bmem_wdata_o, eb[k]);
            expect_eq({tag, "_yumi"}, {63'd0, yumi_o}, 64'd0);
            if (disturb) begin
                data_i       = {4{64'hDEAD_BEEF_0BAD_F00D}};
                addr_i       = 32'hFFFF_FFE0;
                rd_pending_i = 1'b1;
                full_i       = 1'b0;
                empty_i      = k[0];
            end
        end
        @(negedge clk);
        expect_eq({tag, "_ack_yumi"}, {63'd0, yumi_o}, 64'd1);
        expect_eq({tag, "_ack_wr"},   {63'd0, bmem_write_o}, 64'd0);
        expect_eq({tag, "_ack_busy"}, {63'd0, busy_o}, 64'd1);
        empty_i = 1'b1;
    endtask

    initial begin
        l1 = '{64'h1111_0000_0000_00A0, 64'h1111_0000_0000_00A1,
               64'h1111_0000_0000_00A2, 64'h1111_0000_0000_00A3};
        l2 = '{64'h2222_5555_0000_0000, 64'h2222_6666_0000_0001,
               64'h2222_7777_0000_0002, 64'h2222_8888_0000_0003};
        l3 = '{64'h3333_0101_0101_0101, 64'h3333_0202_0202_0202,
               64'h3333_0303_0303_0303, 64'h3333_0404_0404_0404};
        l4 = '{64'h4444_AAAA_BBBB_CC00, 64'h4444_AAAA_BBBB_CC11,
               64'h4444_AAAA_BBBB_CC22, 64'h4444_AAAA_BBBB_CC33};

        rst = 1'b1; empty_i = 1'b0; full_i = 1'b0; rd_pending_i = 1'b0;
        bmem_resp_i = 1'b1; addr_i = 32'h0000_1240; data_i = {l1[3], l1[2], l1[1], l1[0]};
        repeat (2) @(negedge clk);
        check_idle("rst");
        expect_eq("rst_drained", {48'd0, drained_o}, 64'd0);

        // Single line, zero-wait.
        rst = 1'b0;
        run_burst("single", 32'h0000_1240, l1, 1'b0);
        @(negedge clk);
        check_idle("single_done");
        expect_eq("single_drained", {48'd0, drained_o}, 64'd1);

        // Two wait cycles ahead of each accepted beat; offset bits of addr_i are dropped.
        addr_i = 32'h0000_246C; data_i = {l2[3], l2[2], l2[1], l2[0]};
        empty_i = 1'b0; bmem_resp_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                expect_eq("wait_wd",   bmem_wdata_o, l2[k]);
                expect_eq("wait_addr", {32'd0, bmem_address_o}, 64'h0000_2460);
                expect_eq("wait_yumi", {63'd0, yumi_o}, 64'd0);
                if (k == 0 && w == 0) empty_i = 1'b1;
                bmem_resp_i = (w == 2);
            end
        end
        @(negedge clk);
        expect_eq("wait_ack_yumi", {63'd0, yumi_o}, 64'd1);
        bmem_resp_i = 1'b1;
        @(negedge clk);
        check_idle("wait_done");
        expect_eq("wait_drained", {48'd0, drained_o}, 64'd2);

        // Read miss priority until the buffer fills, then input churn mid-burst.
        addr_i = 32'h0000_3300; data_i = {l3[3], l3[2], l3[1], l3[0]};
        empty_i = 1'b0; rd_pending_i = 1'b1; full_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("prio_hold");
        end
        full_i = 1'b1;
        run_burst("stable", 32'h0000_3300, l3, 1'b1);
        rd_pending_i = 1'b0; full_i = 1'b0;
        @(negedge clk);
        check_idle("stable_done");
        expect_eq("stable_drained", {48'd0, drained_o}, 64'd3);

        // Reset while beat 2 is on the bus, then the same entry drains from beat 0.
        addr_i = 32'h0000_8000; data_i = {l4[3], l4[2], l4[1], l4[0]};
        empty_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_eq("abort_wd", bmem_wdata_o, l4[k]);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_rst");
        expect_eq("abort_drained", {48'd0, drained_o}, 64'd0);
        rst = 1'b0;
        run_burst("redrain", 32'h0000_8000, l4, 1'b0);
        @(negedge clk);
        expect_eq("redrain_drained", {48'd0, drained_o}, 64'd1);

        // Three back-to-back entries with a bounded watch window.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; empty_i = 1'b0; pops = 0;
        for (int c = 0; c < 60 && pops < 3; c++) begin
            @(negedge clk);
            if (yumi_o) begin
                yumi_cyc[pops] = c;
                pops++;
                if (pops == 3) empty_i = 1'b1;
            end
        end
        expect_eq("stream_pops", 64'(pops), 64'd3);
        if (pops == 3) begin
            expect_eq("stream_gap0", 64'(yumi_cyc[1] - yumi_cyc[0]), 64'd6);
            expect_eq("stream_gap1", 64'(yumi_cyc[2] - yumi_cyc[1]), 64'd6);
        end
        @(negedge clk);
        expect_eq("stream_drained", {48'd0, drained_o}, 64'd3);
        check_idle("stream_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
